// File: rtl/spi_flash_reader.sv
// SPI mode-0 reader for N25Q flash: READ 0x03, or FAST_READ 0x0B + 8 dummy clocks when FLASH_FAST_READ_EN is defined.
// Latency: first byte valid about 2*CLK_DIV*(header bits + 8) clk after start; one-byte output register.
// Backpressure: SCLK parks low before a byte's last rising edge while the previous byte is still unconsumed.
module spi_flash_reader #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 16,
  parameter int DESEL   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             spi_cs_n_o,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  output logic             spi_wp_n_o,
  output logic             spi_hold_n_o
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
`endif

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DSL_W = (DESEL > 1) ? $clog2(DESEL) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DSL_W-1:0] DSL_LAST = DSL_W'(DESEL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CSLO, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CSHI, S_DESEL
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DSL_W-1:0] dcnt_q, dcnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tx_q, tx_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    dcnt_d  = dcnt_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    if (valid_q && ready_i) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (start_i) begin
          if (len_i != '0) begin
            tx_d    = {RD_CMD, addr_i};
            cnt_d   = len_i;
            busy_d  = 1'b1;
            cs_n_d  = 1'b0;
            mosi_d  = RD_CMD[7];
            div_d   = '0;
            bit_d   = '0;
            state_d = S_CSLO;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_CSLO: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_CMD;
        end
      end

      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (!sclk_q) begin
          // Hold SCLK low ahead of the byte-completing edge until the output slot frees.
          if (state_q == S_DATA && bit_q == 5'd7 && valid_q) begin
            div_d = '0;
          end else if (tick) begin
            div_d  = '0;
            sclk_d = 1'b1;
            if (state_q == S_DATA) begin
              rx_d = {rx_q[5:0], spi_miso_i};
              if (bit_q == 5'd7) begin
                data_d  = {rx_q, spi_miso_i};
                valid_d = 1'b1;
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end else if (tick) begin
          div_d  = '0;
          sclk_d = 1'b0;
          tx_d   = {tx_q[30:0], 1'b0};
          mosi_d = tx_q[30];
          bit_d  = bit_q + 5'd1;
          case (state_q)
            S_CMD: if (bit_q == 5'd7) begin
              bit_d   = '0;
              state_d = S_ADDR;
            end
            S_ADDR: if (bit_q == 5'd23) begin
              bit_d   = '0;
`ifdef FLASH_FAST_READ_EN
              state_d = S_DUMMY;
`else
              state_d = S_DATA;
`endif
            end
            S_DUMMY: if (bit_q == 5'd7) begin
              bit_d   = '0;
              state_d = S_DATA;
            end
            default: if (bit_q == 5'd7) begin
              bit_d = '0;
              if (cnt_q == LEN_W'(1)) state_d = S_CSHI;
              else                    cnt_d   = cnt_q - 1'b1;
            end
          endcase
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_CSHI: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          dcnt_d  = '0;
          state_d = S_DESEL;
        end
      end

      S_DESEL: begin
        dcnt_d = dcnt_q + 1'b1;
        if (dcnt_q == DSL_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      dcnt_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dcnt_q  <= dcnt_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign spi_cs_n_o   = cs_n_q;
  assign spi_sclk_o   = sclk_q;
  assign spi_mosi_o   = mosi_q;
  assign spi_wp_n_o   = 1'b1;
  assign spi_hold_n_o = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural mode-0 flash model plus a byte scoreboard.
module tb_spi_flash_reader;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         HDR = 40;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         HDR = 32;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [15:0] len_i = '0;
  logic        ready_i = 1'b1;
  logic        busy_o, done_o, valid_o;
  logic [7:0]  data_o;
  logic        spi_cs_n_o, spi_sclk_o, spi_mosi_o, spi_wp_n_o, spi_hold_n_o;
  logic        miso_r = 1'b0;

  spi_flash_reader #(.CLK_DIV(2), .LEN_W(16), .DESEL(4)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .spi_cs_n_o(spi_cs_n_o), .spi_sclk_o(spi_sclk_o),
    .spi_mosi_o(spi_mosi_o), .spi_miso_i(miso_r), .spi_wp_n_o(spi_wp_n_o),
    .spi_hold_n_o(spi_hold_n_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int done_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Flash model: captures command/address on rising SCLK, drives DQ1 after falling SCLK.
  logic [7:0]  mem[256];
  int          rises = 0;
  int          cs_falls = 0;
  int          cs_rises = 0;
  logic [31:0] hdr = '0;
  logic        dummy_bad = 1'b0;
  realtime     t_csfall = 0, t_rise1 = 0, t_rise2 = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(spi_cs_n_o, spi_sclk_o) begin
    int idx;
    logic [7:0] b;
    if (prev_cs === 1'b1 && spi_cs_n_o === 1'b0) begin
      rises = 0; hdr = '0; dummy_bad = 1'b0; miso_r = 1'b0;
      cs_falls++; t_csfall = $realtime;
    end
    if (prev_cs === 1'b0 && spi_cs_n_o === 1'b1) cs_rises++;
    if (prev_sclk === 1'b0 && spi_sclk_o === 1'b1) begin
      rises++;
      if (rises == 1) t_rise1 = $realtime;
      if (rises == 2) t_rise2 = $realtime;
      if (rises <= 32) hdr = {hdr[30:0], spi_mosi_o};
      else if (rises <= HDR && spi_mosi_o !== 1'b0) dummy_bad = 1'b1;
    end
    if (prev_sclk === 1'b1 && spi_sclk_o === 1'b0 && rises >= HDR) begin
      idx = rises - HDR;
      b = mem[8'(hdr[7:0] + 8'(idx / 8))];
      miso_r = b[7 - (idx % 8)];
    end
    prev_cs = spi_cs_n_o;
    prev_sclk = spi_sclk_o;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid_o && ready_i && reset_n) begin
      if (exp_q.size() == 0) check("unexpected_byte", {24'h0, data_o}, 32'hFFFF_FFFF);
      else check("stream_byte", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
    end
    if (done_o) done_cnt++;
  end

  task automatic do_start(input logic [23:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    addr_i = a; len_i = l; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_o !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    check("done_seen", {31'h0, done_o}, 32'h1);
    check("busy_low_at_done", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, r0, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", {31'h0, spi_cs_n_o}, 32'h1);
    check("rst_sclk", {31'h0, spi_sclk_o}, 32'h0);
    check("rst_mosi", {31'h0, spi_mosi_o}, 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    check("rst_done", {31'h0, done_o}, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_data", {24'h0, data_o}, 32'h0);
    check("wp_hold", {30'h0, spi_wp_n_o, spi_hold_n_o}, 32'h3);
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic 4-byte read, ready always high
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    d0 = done_cnt;
    do_start(24'h000100, 16'd4);
    check("busy_after_start", {31'h0, busy_o}, 32'h1);
    wait_done();
    @(negedge clk);
    check("done_single_cycle", {31'h0, done_o}, 32'h0);
    check("t1_cmd_addr", hdr, {CMD, 24'h000100});
    check("t1_rises", rises, HDR + 32);
    check("t1_dummy_zero", {31'h0, dummy_bad}, 32'h0);
    check("t1_sclk_period_ns", int'(t_rise2 - t_rise1), 40);
    check("t1_cslo_ns", int'(t_rise1 - t_csfall), 20);
    repeat (4) @(negedge clk);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_drained", exp_q.size(), 0);

    // Backpressure: first byte held 40 cycles
    ready_i = 1'b0;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    r0 = cs_rises;
    do_start(24'h000100, 16'd4);
    n = 0;
    while (valid_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("t2_first_valid", {31'h0, valid_o}, 32'h1);
    repeat (40) @(negedge clk);
    check("t2_frozen_rises", rises, HDR + 15);
    check("t2_frozen_sclk", {31'h0, spi_sclk_o}, 32'h0);
    check("t2_frozen_cs", {31'h0, spi_cs_n_o}, 32'h0);
    check("t2_held_data", {24'h0, data_o}, 32'hA1);
    ready_i = 1'b1;
    wait_done();
    repeat (4) @(negedge clk);
    check("t2_rises", rises, HDR + 32);
    check("t2_cs_rise_once", cs_rises - r0, 1);
    check("t2_drained", exp_q.size(), 0);

    // Zero-length request
    d0 = done_cnt; f0 = cs_falls;
    do_start(24'h000100, 16'd0);
    check("t3_done", {31'h0, done_o}, 32'h1);
    check("t3_busy", {31'h0, busy_o}, 32'h0);
    @(posedge clk); #1;
    check("t3_done_clear", {31'h0, done_o}, 32'h0);
    check("t3_busy_clear", {31'h0, busy_o}, 32'h0);
    check("t3_no_cs", cs_falls - f0, 0);

    // Reset during the address phase, then a fresh single-byte read
    do_start(24'h000100, 16'd4);
    n = 0;
    while (rises < 18 && n < 2000) begin @(negedge clk); n++; end
    check("t4_reach_addr", rises, 18);
    reset_n = 1'b0;
    #1;
    check("t4_rst_cs", {31'h0, spi_cs_n_o}, 32'h1);
    check("t4_rst_sclk", {31'h0, spi_sclk_o}, 32'h0);
    check("t4_rst_busy", {31'h0, busy_o}, 32'h0);
    check("t4_rst_valid", {31'h0, valid_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.push_back(8'hD4);
    do_start(24'h000103, 16'd1);
    wait_done();
    check("t4_cmd_addr", hdr, {CMD, 24'h000103});
    repeat (4) @(negedge clk);
    check("t4_drained", exp_q.size(), 0);

    // Start while busy and during deselect is ignored
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    d0 = done_cnt; f0 = cs_falls;
    do_start(24'h000100, 16'd2);
    repeat (20) @(posedge clk);
    #1 addr_i = 24'h000101; len_i = 16'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n = 0;
    while (spi_cs_n_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("t5_cs_high", {31'h0, spi_cs_n_o}, 32'h1);
    @(posedge clk); #1 addr_i = 24'h000103; len_i = 16'd1; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    check("t5_one_transfer", cs_falls - f0, 1);
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_drained", exp_q.size(), 0);
    exp_q.push_back(8'hC3);
    do_start(24'h000102, 16'd1);
    check("t5_next_accepted", {31'h0, busy_o}, 32'h1);
    wait_done();
    repeat (10) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
